// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the 8x16 register-file access controller.
package regfile_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RWAIT,
        RESP,
        INIT
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/regfile_master.sv
// Initiator for the register file: turns valid/ready requests into WrEn/RdEn strobes,
// absorbs the one-cycle read latency, returns read data, and performs a full clear.
module regfile_master
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    input  logic              init_start,
    output logic              busy,
    output logic [WIDTH-1:0]  WrData,
    output logic [ADDR_W-1:0] Address,
    output logic              WrEn,
    output logic              RdEn,
    input  logic [WIDTH-1:0]  RdData
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic                wren_q, wren_d;
    logic                rden_q, rden_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({{(32-ADDR_W){1'b0}}, a} < DEPTH);
    endfunction

    // Strobes and the register-file address/data are registered so they line up
    // with the WR/RD/INIT state cycle and hold their value when idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            count_q     <= '0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wren_q      <= 1'b0;
            rden_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wren_q      <= wren_d;
            rden_q      <= rden_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wren_d      = 1'b0;
        rden_d      = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (init_start) begin
                    state_d = INIT;
                    count_d = '0;
                    wren_d  = 1'b1;
                    addr_d  = '0;
                    wdata_d = '0;
                end else if (req_valid) begin
                    err_d = !addr_ok(req_addr);
                    if (op_e'(req_write) == OP_WRITE) begin
                        state_d = WR;
                        if (addr_ok(req_addr)) begin
                            wren_d  = 1'b1;
                            addr_d  = req_addr;
                            wdata_d = req_wdata;
                        end
                    end else begin
                        state_d = RD;
                        if (addr_ok(req_addr)) begin
                            rden_d = 1'b1;
                            addr_d = req_addr;
                        end
                    end
                end
            end
            WR:    state_d = IDLE;
            RD:    state_d = RWAIT;
            RWAIT: begin
                // RdData is valid this cycle because RdEn was high in RD.
                rsp_valid_d = 1'b1;
                rsp_rdata_d = err_q ? '0 : RdData;
                rsp_err_d   = err_q;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            INIT: begin
                if (count_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q + 1'b1;
                    wren_d  = 1'b1;
                    addr_d  = count_q + 1'b1;
                    wdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE) && !init_start;
    assign busy      = (state_q != IDLE);
    assign WrEn      = wren_q;
    assign RdEn      = rden_q;
    assign Address   = addr_q;
    assign WrData    = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_regfile_master.sv
// Bench: per-cycle expectation tables filled from transaction timing rules, a
// register-file model, and a DEPTH=6 instance for out-of-range handling.
module tb_regfile_master;

    localparam int W    = 16;
    localparam int D    = 8;
    localparam int AW   = 3;
    localparam int MAXC = 8192;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [W-1:0]  rsp_rdata;
    logic          init_start, busy;
    logic [W-1:0]  WrData, RdData;
    logic [AW-1:0] Address;
    logic          WrEn, RdEn;

    logic          req_valid2, req_ready2, req_write2;
    logic [AW-1:0] req_addr2;
    logic [W-1:0]  req_wdata2;
    logic          rsp_valid2, rsp_ready2, rsp_err2;
    logic [W-1:0]  rsp_rdata2;
    logic          init_start2, busy2;
    logic [W-1:0]  WrData2, RdData2;
    logic [AW-1:0] Address2;
    logic          WrEn2, RdEn2;

    always #5 CLK = ~CLK;

    regfile_master dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .init_start(init_start), .busy(busy),
        .WrData(WrData), .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .RdData(RdData)
    );

    regfile_master #(.DEPTH(6)) dut6 (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
        .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
        .init_start(init_start2), .busy(busy2),
        .WrData(WrData2), .Address(Address2), .WrEn(WrEn2), .RdEn(RdEn2), .RdData(RdData2)
    );

    // Register file: registered read, data valid the cycle after RdEn.
    logic [W-1:0] rf [D];
    always @(posedge CLK) begin
        if (WrEn) rf[Address] <= WrData;
        if (RdEn) RdData <= rf[Address];
    end

    // Expected outputs per cycle, written ahead of time by the stimulus tasks.
    bit           exp_wren [MAXC];
    bit           exp_rden [MAXC];
    bit           exp_busy [MAXC];
    bit           exp_rvalid [MAXC];
    bit           exp_err [MAXC];
    logic [AW-1:0] exp_addr [MAXC];
    logic [W-1:0]  exp_wdata [MAXC];
    logic [W-1:0]  exp_rdata [MAXC];
    logic [W-1:0]  ref_mem [D];

    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    bit           chk_en = 1'b0;
    logic [W-1:0] last_rsp = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, expv);
        end
    endtask

    always @(negedge CLK) begin : compare
        int c;
        if (chk_en) begin
            c = cyc;
            chk("WrEn", 32'(WrEn), 32'(exp_wren[c]));
            if (exp_wren[c]) begin
                chk("Address_wr", 32'(Address), 32'(exp_addr[c]));
                chk("WrData", 32'(WrData), 32'(exp_wdata[c]));
            end
            chk("RdEn", 32'(RdEn), 32'(exp_rden[c]));
            if (exp_rden[c]) chk("Address_rd", 32'(Address), 32'(exp_addr[c]));
            chk("busy", 32'(busy), 32'(exp_busy[c]));
            chk("req_ready", 32'(req_ready), 32'(!exp_busy[c] && !init_start));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rvalid[c]));
            if (exp_rvalid[c]) begin
                chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata[c]));
                chk("rsp_err", 32'(rsp_err), 32'(exp_err[c]));
                if (rsp_valid && rsp_ready) last_rsp = rsp_rdata;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        req_valid  = 1'b0;
        init_start = 1'b0;
    endtask

    // Random request/init activity while busy; none of it may be accepted.
    task automatic junk();
        req_valid  = 1'($urandom);
        req_write  = 1'($urandom);
        req_addr   = 3'($urandom);
        req_wdata  = 16'($urandom);
        init_start = ($urandom_range(0, 3) == 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            quiet();
            rsp_ready = 1'($urandom);
            tick();
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        int t;
        t = cyc;
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        init_start = 1'b0; rsp_ready = 1'($urandom);
        exp_wren[t+1] = 1'b1; exp_addr[t+1] = a; exp_wdata[t+1] = d; exp_busy[t+1] = 1'b1;
        ref_mem[a] = d;
        $display("WRITE cyc=%0d addr=%0d data=%h", t, a, d);
        tick();
        junk();
        tick();
        quiet();
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int stall);
        int t;
        t = cyc;
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = 16'($urandom);
        init_start = 1'b0; rsp_ready = 1'($urandom);
        exp_rden[t+1] = 1'b1; exp_addr[t+1] = a;
        for (int k = 1; k <= 3 + stall; k++) exp_busy[t+k] = 1'b1;
        for (int k = 3; k <= 3 + stall; k++) begin
            exp_rvalid[t+k] = 1'b1;
            exp_rdata[t+k]  = ref_mem[a];
            exp_err[t+k]    = 1'b0;
        end
        $display("READ cyc=%0d addr=%0d stall=%0d expect=%h", t, a, stall, ref_mem[a]);
        for (int k = 1; k <= 3 + stall; k++) begin
            tick();
            junk();
            rsp_ready = (k == 3 + stall) ? 1'b1 : ((k < 3) ? 1'($urandom) : 1'b0);
        end
        tick();
        quiet();
    endtask

    task automatic do_init(input bit keep_req);
        int t;
        t = cyc;
        init_start = 1'b1;
        if (!keep_req) begin
            req_valid = 1'($urandom); req_write = 1'($urandom);
            req_addr = 3'($urandom); req_wdata = 16'($urandom);
        end
        for (int i = 0; i < D; i++) begin
            exp_wren[t+1+i]  = 1'b1;
            exp_addr[t+1+i]  = 3'(i);
            exp_wdata[t+1+i] = '0;
            exp_busy[t+1+i]  = 1'b1;
            ref_mem[i]       = '0;
        end
        $display("INIT cyc=%0d keep_req=%0d", t, keep_req);
        for (int k = 1; k <= D; k++) begin
            tick();
            if (keep_req) init_start = 1'($urandom);
            else junk();
        end
        tick();
        init_start = 1'b0;
        if (!keep_req) req_valid = 1'b0;
    endtask

    task automatic reset_in_rwait(input logic [AW-1:0] a);
        int t;
        t = cyc;
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; init_start = 1'b0;
        exp_rden[t+1] = 1'b1; exp_addr[t+1] = a;
        exp_busy[t+1] = 1'b1; exp_busy[t+2] = 1'b1;
        $display("RESET_IN_RWAIT cyc=%0d addr=%0d", t, a);
        tick();
        junk();
        tick();
        junk();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        quiet();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_WrEn", 32'(WrEn), 32'd0);
        chk("rst_RdEn", 32'(RdEn), 32'd0);
        chk("rst_Address", 32'(Address), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        tick();
    endtask

    initial begin
        RST = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        init_start = 1'b0; rsp_ready = 1'b0;
        req_valid2 = 1'b0; req_write2 = 1'b0; req_addr2 = '0; req_wdata2 = '0;
        init_start2 = 1'b0; rsp_ready2 = 1'b0; RdData2 = 16'h5A5A;
        repeat (3) tick();
        RST = 1'b0;
        chk("reset_WrEn", 32'(WrEn), 32'd0);
        chk("reset_RdEn", 32'(RdEn), 32'd0);
        chk("reset_Address", 32'(Address), 32'd0);
        chk("reset_WrData", 32'(WrData), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk_en = 1'b1;

        do_write(3'd5, 16'hBEEF);
        do_read(3'd5, 0);
        chk("read5_literal", 32'(last_rsp), 32'h0000BEEF);

        for (int i = 0; i < D; i++) do_write(3'(i), 16'(16'h1000 + i));
        do_init(1'b0);
        for (int i = 0; i < D; i++) begin
            do_read(3'(i), $urandom_range(0, 1));
            chk("after_init_literal", 32'(last_rsp), 32'd0);
        end

        do_write(3'd3, 16'h1234);
        do_read(3'd3, 10);
        chk("stall_read_literal", 32'(last_rsp), 32'h00001234);

        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd2; req_wdata = 16'h7777;
        do_init(1'b1);
        do_write(3'd2, 16'h7777);
        do_read(3'd2, 0);
        chk("init_prio_literal", 32'(last_rsp), 32'h00007777);

        reset_in_rwait(3'd2);

        for (int n = 0; n < 200 && cyc < MAXC - 64; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) do_write(3'($urandom), 16'($urandom));
            else if (r < 8) do_read(3'($urandom), ($urandom_range(0, 4) == 0) ? $urandom_range(4, 12) : $urandom_range(0, 3));
            else if (r == 8) do_init(1'b0);
            else idle($urandom_range(1, 3));
        end

        // DEPTH=6 instance: out-of-range read and write, then an in-range read.
        $display("DEPTH6 READ addr=7");
        req_valid2 = 1'b1; req_write2 = 1'b0; req_addr2 = 3'd7;
        tick();
        req_valid2 = 1'b0;
        chk("d6_oor_RdEn_t1", 32'(RdEn2), 32'd0);
        chk("d6_oor_busy_t1", 32'(busy2), 32'd1);
        tick();
        chk("d6_oor_RdEn_t2", 32'(RdEn2), 32'd0);
        tick();
        chk("d6_oor_rsp_valid", 32'(rsp_valid2), 32'd1);
        chk("d6_oor_rsp_rdata", 32'(rsp_rdata2), 32'd0);
        chk("d6_oor_rsp_err", 32'(rsp_err2), 32'd1);
        rsp_ready2 = 1'b1;
        tick();
        rsp_ready2 = 1'b0;
        chk("d6_oor_rsp_done", 32'(rsp_valid2), 32'd0);
        chk("d6_oor_idle", 32'(busy2), 32'd0);

        $display("DEPTH6 WRITE addr=6");
        req_valid2 = 1'b1; req_write2 = 1'b1; req_addr2 = 3'd6; req_wdata2 = 16'hABCD;
        tick();
        req_valid2 = 1'b0;
        chk("d6_oor_WrEn", 32'(WrEn2), 32'd0);
        chk("d6_oor_wr_busy", 32'(busy2), 32'd1);
        tick();
        chk("d6_oor_wr_idle", 32'(busy2), 32'd0);
        chk("d6_oor_WrEn_t2", 32'(WrEn2), 32'd0);

        $display("DEPTH6 READ addr=5");
        req_valid2 = 1'b1; req_write2 = 1'b0; req_addr2 = 3'd5;
        tick();
        req_valid2 = 1'b0;
        chk("d6_ok_RdEn", 32'(RdEn2), 32'd1);
        chk("d6_ok_Address", 32'(Address2), 32'd5);
        tick();
        tick();
        chk("d6_ok_rsp_valid", 32'(rsp_valid2), 32'd1);
        chk("d6_ok_rsp_rdata", 32'(rsp_rdata2), 32'h00005A5A);
        chk("d6_ok_rsp_err", 32'(rsp_err2), 32'd0);
        rsp_ready2 = 1'b1;
        tick();
        rsp_ready2 = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_master.md
# regfile_master

Request-driven access controller that acts as the initiator for the 8×16 register file. It accepts read/write requests on a valid/ready interface and converts them into single-cycle WrEn/RdEn strobes on the register-file port. It absorbs the register file's one-cycle registered read latency and returns read data on a valid/ready response channel. It also provides a sequential clear (init) of all entries.

## Interface
- WIDTH, 16, data width of the register file
- DEPTH, 8, number of implemented entries
- ADDR_W, 3, address width; DEPTH ≤ 2^ADDR_W

Clocking and reset: one clock; reset is synchronous and active-high.

- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  target entry
- req_wdata  in  WIDTH  write data
- rsp_valid  out  1  read response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  WIDTH  read data
- rsp_err  out  1  address ≥ DEPTH
- init_start  in  1  start clear of all entries (sampled in IDLE only)
- busy  out  1  state ≠ IDLE
- WrData  out  WIDTH  to register file
- Address  out  ADDR_W  to register file
- WrEn  out  1  write strobe
- RdEn  out  1  read strobe
- RdData  in  WIDTH  from register file; valid one cycle after RdEn

## Operation
- States: IDLE, WR, RD, RWAIT, RESP, INIT.
- req_ready = (state == IDLE) && !init_start. It is combinational from state and init_start.
- IDLE:
  - If init_start is high: go to INIT with count = 0. init_start has priority over req_valid.
  - Else, on accept: latch addr, wdata, and op. Go to WR (write) or RD (read).
- WR: WrEn = 1 for one cycle with latched Address/WrData, then IDLE. A write produces no response.
- RD: RdEn = 1 for one cycle, then RWAIT.
- RWAIT: capture RdData into rsp_rdata at the end of the cycle, then RESP.
- RESP: rsp_valid = 1 until rsp_valid && rsp_ready, then IDLE. rsp_rdata and rsp_err are held stable while rsp_valid is high.
- Out-of-range address (addr ≥ DEPTH):
  - Write: no WrEn pulse; return to IDLE after one cycle in WR.
  - Read: no RdEn pulse; the response has rsp_rdata = 0 and rsp_err = 1.
- INIT:
  - WrEn = 1 and WrData = 0 every cycle, with Address = count.
  - count increments each cycle. After count == DEPTH-1 is written, go to IDLE. Duration is DEPTH cycles.
- WrEn and RdEn are never high together. Both are 0 outside WR, RD, and INIT.
- Address and WrData hold their last value when strobes are low.

## Timing
- Reset values: state IDLE, WrEn 0, RdEn 0, Address 0, WrData 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, count 0. req_ready is 1 when init_start is low.
- Reset in any state aborts the operation. No pending strobe or response survives the reset edge.
- Write accepted in cycle T: WrEn high in T+1. req_ready high again in T+2. Throughput is 1 write per 2 cycles.
- Read accepted in cycle T:
  - RdEn high in T+1.
  - RdData valid in T+2 and captured at the end of T+2.
  - rsp_valid high from T+3.
  - Minimum turnaround with rsp_ready held high: 4 cycles per read.
- Response backpressure: rsp_valid stays high indefinitely. No new request is accepted until the response is taken.
- init_start asserted in IDLE at cycle T: WrEn high during T+1 … T+DEPTH; IDLE again at T+DEPTH+1.
- init_start outside IDLE is ignored (not queued).

## Structure
- Shared package regfile_pkg holds:
  - state enum (IDLE, WR, RD, RWAIT, RESP, INIT)
  - op encoding (OP_READ = 0, OP_WRITE = 1)
  - default WIDTH, DEPTH, ADDR_W constants
- Single module; no sub-module. The bench pairs it with the existing register file and a scoreboard model of DEPTH entries.

## Test plan
- Write addr 5, data 0xBEEF, then read addr 5 with rsp_ready = 1. Expect:
  - WrEn 1 cycle after the write accept.
  - RdEn 1 cycle after the read accept.
  - rsp_valid 3 cycles after the read accept with rsp_rdata 0xBEEF, rsp_err 0.
- Fill all 8 entries with 0x1000+i, then init_start. Expect:
  - 8 consecutive WrEn cycles with Address 0..7 and WrData 0.
  - busy low after them.
  - Subsequent reads of all entries return 0x0000.
- Read with rsp_ready held low for 10 cycles. Expect:
  - rsp_valid and rsp_rdata stable throughout.
  - req_ready low throughout.
  - IDLE one cycle after rsp_ready rises.
- init_start and req_valid high in the same IDLE cycle. Expect INIT entered, request not accepted, request accepted after init completes.
- DEPTH = 6, read addr 7. Expect no RdEn, rsp_rdata 0, rsp_err 1. Write addr 6: expect no WrEn pulse.
- RST asserted in RWAIT. Expect:
  - All outputs at reset values next cycle.
  - No rsp_valid.
  - req_ready 1.
